// File: rtl/mat_vec_mult.sv
// rtl/mat_vec_mult.sv - sequential Q-format vector x matrix multiplier, one MAC per cycle.
// Walks each column over all rows, then emits one saturated result element per column.
module mat_vec_mult #(
  parameter int ROWS = 4,
  parameter int COLS = 32,
  parameter int FRAC = 8,
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  output logic          busy,
  output logic          ready,
  output logic [RW-1:0] mat_row,
  output logic [CW-1:0] mat_col,
  input  logic [15:0]   mat_data,
  input  logic [15:0]   vec_data,
  output logic          res_we,
  output logic [CW-1:0] res_idx,
  output logic [15:0]   res_data
);

  // Accumulator holds ROWS full products without overflow, plus a sign guard bit.
  localparam int AW = 32 + $clog2(ROWS) + 1;
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);
  localparam logic signed [AW-1:0] SAT_MAX = AW'(32767);
  localparam logic signed [AW-1:0] SAT_MIN = AW'(-32768);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_WRITE,
    S_DONE
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [RW-1:0]        r_row;
  logic [RW-1:0]        w_row_nxt;
  logic [CW-1:0]        r_col;
  logic [CW-1:0]        w_col_nxt;
  logic signed [AW-1:0] r_acc;
  logic signed [AW-1:0] w_acc_nxt;

  logic signed [31:0]   w_prod;
  logic signed [AW-1:0] w_prod_ext;
  logic signed [AW-1:0] w_shift;
  logic [15:0]          w_sat;

  assign w_prod     = $signed(vec_data) * $signed(mat_data);
  assign w_prod_ext = {{(AW - 32){w_prod[31]}}, w_prod};
  // Arithmetic shift floors toward minus infinity; no rounding is applied.
  assign w_shift    = r_acc >>> FRAC;

  always_comb begin
    if (w_shift > SAT_MAX) begin
      w_sat = 16'h7FFF;
    end else if (w_shift < SAT_MIN) begin
      w_sat = 16'h8000;
    end else begin
      w_sat = w_shift[15:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_row   <= '0;
      r_col   <= '0;
      r_acc   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_row   <= w_row_nxt;
      r_col   <= w_col_nxt;
      r_acc   <= w_acc_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    w_col_nxt   = r_col;
    w_acc_nxt   = r_acc;
    busy        = 1'b0;
    ready       = 1'b0;
    res_we      = 1'b0;
    res_data    = 16'h0000;

    case (r_state)
      S_IDLE: begin
        // abort outranks start so a cancel issued alongside a request wins.
        if (start && !abort) begin
          w_state_nxt = S_MAC;
          w_row_nxt   = '0;
          w_col_nxt   = '0;
          w_acc_nxt   = '0;
        end
      end

      S_MAC: begin
        busy = 1'b1;
        if (abort) begin
          w_state_nxt = S_IDLE;
          w_row_nxt   = '0;
          w_col_nxt   = '0;
          w_acc_nxt   = '0;
        end else begin
          w_acc_nxt = r_acc + w_prod_ext;
          if (r_row == LAST_ROW) begin
            w_state_nxt = S_WRITE;
          end else begin
            w_row_nxt = r_row + RW'(1);
          end
        end
      end

      S_WRITE: begin
        // The write strobe is unconditional here: an abort only stops what follows.
        busy      = 1'b1;
        res_we    = 1'b1;
        res_data  = w_sat;
        w_acc_nxt = '0;
        w_row_nxt = '0;
        if (abort) begin
          w_state_nxt = S_IDLE;
          w_col_nxt   = '0;
        end else if (r_col == LAST_COL) begin
          w_state_nxt = S_DONE;
        end else begin
          w_col_nxt   = r_col + CW'(1);
          w_state_nxt = S_MAC;
        end
      end

      S_DONE: begin
        busy        = 1'b1;
        ready       = 1'b1;
        w_state_nxt = S_IDLE;
        w_col_nxt   = '0;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign mat_row = r_row;
  assign mat_col = r_col;
  assign res_idx = r_col;

endmodule

// File: tb/tb_mat_vec_mult.sv
// tb/tb_mat_vec_mult.sv - bench for mat_vec_mult with 4x32 and 32x32 instances.
module tb_mat_vec_mult;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start4, abort4, start32, abort32;
  logic        busy4, ready4, we4, busy32, ready32, we32;
  logic [1:0]  row4;
  logic [4:0]  row32, col4, col32, idx4, idx32;
  logic [15:0] md4, vd4, md32, vd32, rd4, rd32;

  logic [15:0] vec_m [32];
  logic [15:0] mat_m [32][32];

  assign md4  = mat_m[{3'b000, row4}][col4];
  assign vd4  = vec_m[{3'b000, row4}];
  assign md32 = mat_m[row32][col32];
  assign vd32 = vec_m[row32];

  mat_vec_mult #(.ROWS(4), .COLS(32), .FRAC(8)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort4),
    .busy(busy4), .ready(ready4), .mat_row(row4), .mat_col(col4),
    .mat_data(md4), .vec_data(vd4), .res_we(we4), .res_idx(idx4), .res_data(rd4)
  );

  mat_vec_mult #(.ROWS(32), .COLS(32), .FRAC(8)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .abort(abort32),
    .busy(busy32), .ready(ready32), .mat_row(row32), .mat_col(col32),
    .mat_data(md32), .vec_data(vd32), .res_we(we32), .res_idx(idx32), .res_data(rd32)
  );

  typedef struct {
    logic [4:0]  idx;
    logic [15:0] data;
  } exp_t;

  typedef struct {
    bit          big;
    logic [15:0] v0;
    logic [15:0] vr;
    logic [15:0] m0;
    logic [15:0] mr;
    bit          rnd;
    logic [15:0] exp;
    string       nm;
  } tv_t;

  exp_t sb[$];
  tv_t  tv[9];
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_writes = 0;
  bit   sel = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  logic [4:0]  mon_idx;
  logic [15:0] mon_data;
  exp_t        mon_e;
  always @(negedge clk) begin
    if (we4 || we32) begin
      n_writes++;
      mon_idx  = we32 ? idx32 : idx4;
      mon_data = we32 ? rd32 : rd4;
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got idx %0d data 0x%0h expected no write", mon_idx, mon_data);
      end else begin
        mon_e = sb.pop_front();
        if (mon_idx !== mon_e.idx || mon_data !== mon_e.data) begin
          n_fail++;
          $display("FAIL result: got idx %0d data 0x%0h expected idx %0d data 0x%0h",
                   mon_idx, mon_data, mon_e.idx, mon_e.data);
        end
      end
    end
  end

  function automatic logic [15:0] model(input int nrows, input int c);
    longint s;
    s = 0;
    for (int r = 0; r < nrows; r++) begin
      s += longint'($signed(vec_m[r])) * longint'($signed(mat_m[r][c]));
    end
    s = s >>> 8;
    if (s > 32767) return 16'h7FFF;
    if (s < -32768) return 16'h8000;
    return s[15:0];
  endfunction

  task automatic fill(input logic [15:0] v0, input logic [15:0] vr,
                      input logic [15:0] m0, input logic [15:0] mr, input bit rnd);
    for (int r = 0; r < 32; r++) begin
      vec_m[r] = rnd ? 16'($urandom) : ((r == 0) ? v0 : vr);
      for (int c = 0; c < 32; c++) begin
        mat_m[r][c] = rnd ? 16'($urandom) : ((r == 0) ? m0 : mr);
      end
    end
  endtask

  task automatic push_expected(input int nrows, input bit use_model, input logic [15:0] e);
    exp_t x;
    for (int c = 0; c < 32; c++) begin
      x.idx  = 5'(c);
      x.data = use_model ? model(nrows, c) : e;
      sb.push_back(x);
    end
  endtask

  task automatic set_start(input bit v);
    if (sel) start32 = v;
    else start4 = v;
  endtask

  function automatic logic cur_ready();
    return sel ? ready32 : ready4;
  endfunction

  function automatic logic cur_busy();
    return sel ? busy32 : busy4;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, " busy4"}, {31'b0, busy4}, 0);
    check({tag, " ready4"}, {31'b0, ready4}, 0);
    check({tag, " res_we4"}, {31'b0, we4}, 0);
    check({tag, " mat_row4"}, {30'b0, row4}, 0);
    check({tag, " mat_col4"}, {27'b0, col4}, 0);
    check({tag, " res_idx4"}, {27'b0, idx4}, 0);
    check({tag, " res_data4"}, {16'b0, rd4}, 0);
    check({tag, " busy32"}, {31'b0, busy32}, 0);
    check({tag, " res_we32"}, {31'b0, we32}, 0);
    check({tag, " mat_row32"}, {27'b0, row32}, 0);
    check({tag, " res_data32"}, {16'b0, rd32}, 0);
  endtask

  // Pulses start, optionally re-pulses it at edge restart_at, and measures ready latency.
  task automatic start_and_wait(input int lat, input string nm, input int restart_at);
    int n;
    bit got;
    set_start(1'b1);
    @(posedge clk);
    #1;
    set_start(1'b0);
    check({nm, " busy_after_start"}, {31'b0, cur_busy()}, 1);
    n = 0;
    got = 1'b0;
    while (!got && n < lat + 64) begin
      @(posedge clk);
      n++;
      #1;
      set_start(n == restart_at - 1);
      if (cur_ready()) got = 1'b1;
    end
    set_start(1'b0);
    check({nm, " ready_latency"}, got ? n : -1, lat);
    check({nm, " busy_in_done"}, {31'b0, cur_busy()}, 1);
    @(posedge clk);
    #1;
    check({nm, " ready_one_cycle"}, {31'b0, cur_ready()}, 0);
    check({nm, " busy_after_done"}, {31'b0, cur_busy()}, 0);
    check({nm, " writes_outstanding"}, sb.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion expected finish before timeout");
    $fatal(1, "watchdog");
  end

  int  w0;
  bit  rdy_seen;

  initial begin
    rst_n = 1'b0;
    start4 = 1'b0; abort4 = 1'b0; start32 = 1'b0; abort32 = 1'b0;
    fill(16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
    #2;
    check_idle_outputs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    tv[0] = '{1'b0, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 1'b0, 16'h0400, "ones4x32"};
    tv[1] = '{1'b0, 16'hFF00, 16'h0000, 16'h0200, 16'h0000, 1'b0, 16'hFE00, "neg"};
    tv[2] = '{1'b0, 16'hFFFF, 16'h0000, 16'h0001, 16'h0000, 1'b0, 16'hFFFF, "floor"};
    tv[3] = '{1'b0, 16'h0001, 16'h0000, 16'h0001, 16'h0000, 1'b0, 16'h0000, "tiny"};
    tv[4] = '{1'b0, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b0, 16'h7FFF, "sat4"};
    tv[5] = '{1'b1, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b0, 16'h7FFF, "satmax32"};
    tv[6] = '{1'b1, 16'h7FFF, 16'h7FFF, 16'h8001, 16'h8001, 1'b0, 16'h8000, "satmin32"};
    tv[7] = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'h0000, "rand4"};
    tv[8] = '{1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'h0000, "rand32"};

    for (int i = 0; i < 9; i++) begin
      sel = tv[i].big;
      fill(tv[i].v0, tv[i].vr, tv[i].m0, tv[i].mr, tv[i].rnd);
      push_expected(sel ? 32 : 4, tv[i].rnd, tv[i].exp);
      start_and_wait(sel ? 1056 : 160, tv[i].nm, -1);
      @(negedge clk);
    end

    sel = 1'b0;
    abort4 = 1'b1;
    start4 = 1'b1;
    @(posedge clk);
    #1;
    check("abort_over_start busy", {31'b0, busy4}, 0);
    abort4 = 1'b0;
    start4 = 1'b0;
    @(negedge clk);

    fill(16'h0100, 16'h0100, 16'h0100, 16'h0100, 1'b0);
    push_expected(4, 1'b0, 16'h0400);
    start_and_wait(160, "restart_ignored", 20);

    @(negedge clk);
    push_expected(4, 1'b0, 16'h0400);
    w0 = n_writes;
    start4 = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    for (int k = 1; k <= 49; k++) begin
      @(posedge clk);
      #1;
    end
    abort4 = 1'b1;
    @(posedge clk);
    #1;
    abort4 = 1'b0;
    check("abort busy", {31'b0, busy4}, 0);
    check("abort write_count", n_writes - w0, 10);
    sb.delete();
    rdy_seen = 1'b0;
    w0 = n_writes;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (ready4) rdy_seen = 1'b1;
    end
    check("abort no_ready", {31'b0, rdy_seen}, 0);
    check("abort no_more_writes", n_writes - w0, 0);
    @(negedge clk);
    push_expected(4, 1'b0, 16'h0400);
    start_and_wait(160, "after_abort", -1);

    @(negedge clk);
    push_expected(4, 1'b0, 16'h0400);
    start4 = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    for (int k = 1; k <= 69; k++) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    check_idle_outputs("mid_reset");
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    fill(16'h0100, 16'h0100, 16'h0100, 16'h0100, 1'b1);
    push_expected(4, 1'b1, 16'h0000);
    rst_n = 1'b1;
    start_and_wait(160, "post_reset", -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mat_vec_mult.md
MAT_VEC_MULT -- requirements
Module: mat_vec_mult

Interface
REQ-001 SHALL have parameter ROWS, default 4, meaning input vector length and matrix row count (4 for weights, 32 for recurrent).
REQ-002 SHALL have parameter COLS, default 32, meaning matrix column count and output vector length.
REQ-003 SHALL have parameter FRAC, default 8, meaning fractional bits of the signed 16-bit fixed-point format (Q8.8).
REQ-004 SHALL have clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have start  input  1  pulse requesting one multiply.
REQ-007 SHALL have abort  input  1  synchronous cancel of the multiply in progress.
REQ-008 SHALL have busy  output  1  high while a multiply is in progress.
REQ-009 SHALL have ready  output  1  one-cycle pulse on completion.
REQ-010 SHALL have mat_row  output  RW=max(1,clog2(ROWS))  registered row index, also the vector index.
REQ-011 SHALL have mat_col  output  CW=max(1,clog2(COLS))  registered column index.
REQ-012 SHALL have mat_data  input  16  signed matrix[mat_row][mat_col], combinational from the owner, valid in the same cycle.
REQ-013 SHALL have vec_data  input  16  signed vector[mat_row], same timing as mat_data.
REQ-014 SHALL have res_we  output  1  result element write strobe.
REQ-015 SHALL have res_idx  output  CW  result element index.
REQ-016 SHALL have res_data  output  16  signed result element.

Function
REQ-017 SHALL compute res[c] = sat16((sum over r of vec[r]*mat[r][c]) >>> FRAC) for c = 0..COLS-1.
REQ-018 SHALL form full 32-bit signed products and accumulate at width 32+clog2(ROWS)+1 with no intermediate overflow.
REQ-019 SHALL apply an arithmetic right shift (floor, no rounding), then saturate to [-32768, 32767].
REQ-020 SHALL implement the states IDLE, MAC, WRITE and DONE.
REQ-021 IDLE: when start=1, SHALL load mat_row=0, mat_col=0, clear the accumulator, assert busy and enter MAC.
REQ-022 MAC: each cycle SHALL add vec_data*mat_data to the accumulator; at mat_row=ROWS-1 SHALL go to WRITE, otherwise increment mat_row.
REQ-023 WRITE: SHALL drive res_we=1, res_idx=mat_col and res_data for exactly one cycle, clear the accumulator and set mat_row=0.
REQ-024 WRITE: if mat_col=COLS-1 SHALL go to DONE, otherwise increment mat_col and return to MAC.
REQ-025 DONE: SHALL drive ready=1 for one cycle, deassert busy and return to IDLE.
REQ-026 Latency: ready SHALL be high in the cycle COLS*(ROWS+1) clock edges after the edge that sampled start (160 for 4x32, 1056 for 32x32).
REQ-027 busy SHALL be high from the edge after start is sampled up to and including the DONE cycle.
REQ-028 start while busy SHALL be ignored, with no restart and no queuing.
REQ-029 abort=1 in MAC or WRITE SHALL return to IDLE on the next edge, with busy low, no ready and no further res_we.
REQ-030 abort=1 in the WRITE cycle SHALL still let that cycle's res_we occur.
REQ-031 abort=1 in IDLE SHALL have no effect; abort has priority over start in the same cycle.
REQ-032 res_we SHALL be 0 outside WRITE; ready SHALL be 0 outside DONE.
REQ-033 res_idx SHALL visit 0..COLS-1 exactly once each, in ascending order.
REQ-034 The block SHALL not latch mat_data or vec_data outside MAC; the owner keeps the operands stable while busy=1.

Reset
REQ-035 rst_n=0 SHALL immediately (asynchronously) force state IDLE and busy=0, ready=0, res_we=0, mat_row=0, mat_col=0, res_idx=0, res_data=0 and accumulator=0.
REQ-036 Reset asserted mid-operation SHALL discard all progress; after release the block SHALL wait in IDLE for a new start.
REQ-037 The first edge after rst_n rises SHALL sample start normally.

Verification
REQ-038 ROWS=4, COLS=32: all vec=0x0100, all mat=0x0100, start -> 32 writes of 0x0400 at idx 0..31, ready exactly 160 edges after start, one-cycle pulse.
REQ-039 vec[0]=0xFF00, mat[0][c]=0x0200, all other operands 0 -> every res=0xFE00; vec[0]=0xFFFF, mat[0][c]=0x0001 -> res=0xFFFF (floor); vec[0]=0x0001 -> res=0x0000.
REQ-040 ROWS=32: all vec=0x7FFF, all mat=0x7FFF -> every res=0x7FFF; with mat=0x8001 instead -> every res=0x8000.
REQ-041 start pulsed again at cycle 20 of a run -> no restart, ready still at edge 160; abort at cycle 50 -> busy=0 next edge, no ready, exactly 10 res_we seen; a new start then completes normally.
REQ-042 rst_n pulled low at cycle 70 -> all outputs 0 with no clock edge; after release, a start completes with correct results at the nominal latency.
